// File: rtl/pio_dout_pkg.sv
// Shared register map, bit positions and sizing helper for the processor output stream port.
package pio_dout_pkg;

  typedef enum logic [1:0] {
    RegData    = 2'd0,
    RegStatus  = 2'd1,
    RegControl = 2'd2,
    RegThresh  = 2'd3
  } reg_addr_e;

  localparam int unsigned StEmptyBit  = 0;
  localparam int unsigned StFullBit   = 1;
  localparam int unsigned StOvfBit    = 2;
  localparam int unsigned StLevelLsb  = 16;

  localparam int unsigned CtlEnableBit = 0;
  localparam int unsigned CtlFlushBit  = 1;
  localparam int unsigned CtlIrqEnBit  = 2;

  // Level must be able to hold DEPTH itself, hence one bit more than the pointers.
  function automatic int unsigned level_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pio_sync_fifo.sv
// First-word-fall-through synchronous FIFO; caller guarantees push only when room and pop only
// when non-empty.
module pio_sync_fifo
  import pio_dout_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned LevelW = level_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [LevelW-1:0] level_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic              push_eff, pop_eff;

  assign push_eff = push_i && !flush_i;
  assign pop_eff  = pop_i && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_eff)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push_eff, pop_eff})
        2'b10:   level_d = level_q + LevelW'(1);
        2'b01:   level_d = level_q - LevelW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Gate the head so the port reads 0 while empty rather than stale storage.
  assign out_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o    = level_q;
  assign empty_o    = (level_q == '0);
  assign full_o     = (level_q == LevelW'(DEPTH));

endmodule

// File: rtl/processor_dout_stream.sv
// Avalon-MM slave feeding a FIFO that drains onto a valid/ready stream.
// Optional low-water interrupt, THRESH register and CONTROL.irq_en under PIO_DOUT_IRQ_EN.
module processor_dout_stream
  import pio_dout_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef PIO_DOUT_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int unsigned LevelW = level_width(DEPTH);

  logic              wr_en;
  logic              wr_data, wr_status, wr_control;
  logic              push_req, push_ok, pop, flush;
  logic              empty, full;
  logic [LevelW-1:0] level;
  logic [DATA_W-1:0] shadow_q;
  logic              enable_q;
  logic              overflow_q;

  assign wr_en      = chipselect && !write_n;
  assign wr_data    = wr_en && (reg_addr_e'(address) == RegData);
  assign wr_status  = wr_en && (reg_addr_e'(address) == RegStatus);
  assign wr_control = wr_en && (reg_addr_e'(address) == RegControl);

  assign out_valid = enable_q && !empty;
  assign pop       = out_valid && out_ready;
  assign push_req  = wr_data;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok   = push_req && (!full || pop);
  assign flush     = wr_control && writedata[CtlFlushBit];

  pio_sync_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (push_ok),
    .push_data_i(writedata[DATA_W-1:0]),
    .pop_i      (pop),
    .flush_i    (flush),
    .out_data_o (out_data),
    .level_o    (level),
    .empty_o    (empty),
    .full_o     (full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q   <= '0;
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_data)    shadow_q <= writedata[DATA_W-1:0];
      if (wr_control) enable_q <= writedata[CtlEnableBit];
      if (push_req && !push_ok) begin
        overflow_q <= 1'b1;
      end else if (wr_status && writedata[StOvfBit]) begin
        overflow_q <= 1'b0;
      end
    end
  end

`ifdef PIO_DOUT_IRQ_EN
  logic       wr_thresh;
  logic       irq_en_q;
  logic [7:0] thresh_q;
  logic       irq_q;

  assign wr_thresh = wr_en && (reg_addr_e'(address) == RegThresh);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_control) irq_en_q <= writedata[CtlIrqEnBit];
      if (wr_thresh)  thresh_q <= writedata[7:0];
      // Uses the current level, so irq lags the level by one cycle.
      irq_q <= irq_en_q && (32'(level) <= 32'(thresh_q));
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    readdata = '0;
    unique case (reg_addr_e'(address))
      RegData: readdata = 32'(shadow_q);
      RegStatus: begin
        readdata[StEmptyBit]               = empty;
        readdata[StFullBit]                = full;
        readdata[StOvfBit]                 = overflow_q;
        readdata[StLevelLsb +: LevelW]     = level;
      end
      RegControl: begin
        readdata[CtlEnableBit] = enable_q;
`ifdef PIO_DOUT_IRQ_EN
        readdata[CtlIrqEnBit]  = irq_en_q;
`endif
      end
      RegThresh: begin
`ifdef PIO_DOUT_IRQ_EN
        readdata[7:0] = thresh_q;
`endif
      end
    endcase
  end

endmodule
